// File: rtl/iq_index_free_list.sv
// -----------------------------------------------------------------------------
// iq_index_free_list
//   Free list of issue-queue entry indices between dispatch and the issue queue.
//   After reset an init FSM fills the circular buffer with every index
//   (RELEASE_WIDTH+RETURN_WIDTH per cycle). In READY, dispatch pops up to
//   DISPATCH_WIDTH indices per cycle. Indices are pushed back from
//   issue/select (release lanes) and from the selective-flush return port.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   allocReq       per-lane pop request (prefix-shaped)
//   allocPtr       lane i = storage[head+i], combinational
//   canAlloc       READY and at least DISPATCH_WIDTH indices free
//   releaseValid/releasePtr   issue-release pushes
//   returnValid/returnPtr     flush-return pushes
//   freeCount      registered number of free indices
//   initDone       high in READY
//   errOverflow    sticky: a push would have exceeded ENTRY_NUM
//   dbgState       FSM state (0 = INIT, 1 = READY)
//
// Handshake: a pop happens on a rising clock edge for every lane with
//   allocReq set while canAlloc is high; allocPtr is valid in that same cycle.
//   Requests while canAlloc is low are dropped. Push lanes have no
//   backpressure: a valid lane is taken on the edge unless the whole cycle's
//   pushes are dropped for overflow.
// -----------------------------------------------------------------------------
module iq_index_free_list #(
  parameter int ENTRY_NUM      = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int RELEASE_WIDTH  = 4,
  parameter int RETURN_WIDTH   = 2,
  parameter int IDX_W          = $clog2(ENTRY_NUM)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DISPATCH_WIDTH-1:0]       allocReq,
  output logic [DISPATCH_WIDTH*IDX_W-1:0] allocPtr,
  output logic                            canAlloc,
  input  logic [RELEASE_WIDTH-1:0]        releaseValid,
  input  logic [RELEASE_WIDTH*IDX_W-1:0]  releasePtr,
  input  logic [RETURN_WIDTH-1:0]         returnValid,
  input  logic [RETURN_WIDTH*IDX_W-1:0]   returnPtr,
  output logic [IDX_W:0]                  freeCount,
  output logic                            initDone,
  output logic                            errOverflow,
  output logic                            dbgState
);

  localparam int PUSH_W = RELEASE_WIDTH + RETURN_WIDTH;
  localparam int CNT_W  = IDX_W + 1;
  // Arithmetic width with headroom for count + pushes before the overflow test.
  localparam int CW     = $clog2(ENTRY_NUM + PUSH_W + DISPATCH_WIDTH + 1) + 1;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } fillStateT;

  fillStateT          state, stateNext;
  logic [IDX_W-1:0]   head, headNext;
  logic [IDX_W-1:0]   tail, tailNext;
  logic [CNT_W-1:0]   count, countNext;
  logic [CNT_W-1:0]   initCnt, initCntNext;
  logic               ovfSet;

  logic [IDX_W-1:0]   mem [ENTRY_NUM];

  // Push lanes in compaction order: release lanes first, then return lanes.
  logic [PUSH_W-1:0]  laneValid;
  logic [IDX_W-1:0]   lanePtr [PUSH_W];

  logic               wrEn   [PUSH_W];
  logic [IDX_W-1:0]   wrAddr [PUSH_W];
  logic [IDX_W-1:0]   wrData [PUSH_W];

  logic [CW-1:0]      popCnt, pushCnt, initStep, countSum;

  assign laneValid = {returnValid, releaseValid};

  always_comb begin
    lanePtr = '{default: '0};
    for (int l = 0; l < RELEASE_WIDTH; l++) begin
      lanePtr[l] = releasePtr[l*IDX_W +: IDX_W];
    end
    for (int l = 0; l < RETURN_WIDTH; l++) begin
      lanePtr[RELEASE_WIDTH+l] = returnPtr[l*IDX_W +: IDX_W];
    end
  end

  assign canAlloc    = (state == ST_READY) && (count >= CNT_W'(DISPATCH_WIDTH));
  assign initDone    = (state == ST_READY);
  assign freeCount   = count;
  assign dbgState    = state;

  // No bypass: pops always read what is already stored at head.
  always_comb begin
    allocPtr = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      allocPtr[i*IDX_W +: IDX_W] = mem[head + IDX_W'(i)];
    end
  end

  always_comb begin
    stateNext   = state;
    headNext    = head;
    tailNext    = tail;
    countNext   = count;
    initCntNext = initCnt;
    ovfSet      = 1'b0;
    popCnt      = '0;
    pushCnt     = '0;
    initStep    = '0;
    countSum    = '0;
    for (int j = 0; j < PUSH_W; j++) begin
      wrEn[j]   = 1'b0;
      wrAddr[j] = '0;
      wrData[j] = '0;
    end

    case (state)
      ST_INIT: begin
        // Last fill cycle writes only the remainder.
        if (CW'(ENTRY_NUM) - CW'(initCnt) < CW'(PUSH_W)) begin
          initStep = CW'(ENTRY_NUM) - CW'(initCnt);
        end else begin
          initStep = CW'(PUSH_W);
        end
        for (int j = 0; j < PUSH_W; j++) begin
          if (CW'(j) < initStep) begin
            wrEn[j]   = 1'b1;
            wrAddr[j] = tail + IDX_W'(j);
            wrData[j] = initCnt[IDX_W-1:0] + IDX_W'(j);
          end
        end
        tailNext    = tail + IDX_W'(initStep);
        countNext   = count + CNT_W'(initStep);
        initCntNext = initCnt + CNT_W'(initStep);
        if (CW'(initCnt) + initStep == CW'(ENTRY_NUM)) begin
          stateNext = ST_READY;
        end
      end

      ST_READY: begin
        if (canAlloc) begin
          for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            popCnt = popCnt + CW'(allocReq[i]);
          end
        end
        // Each valid lane lands at tail + (number of valid lanes before it).
        for (int l = 0; l < PUSH_W; l++) begin
          if (laneValid[l]) begin
            wrEn[l]   = 1'b1;
            wrAddr[l] = tail + IDX_W'(pushCnt);
            wrData[l] = lanePtr[l];
            pushCnt   = pushCnt + CW'(1);
          end
        end
        countSum = CW'(count) - popCnt + pushCnt;
        // Overflow drops the whole cycle's pushes; pops still proceed.
        if (countSum > CW'(ENTRY_NUM)) begin
          ovfSet  = 1'b1;
          pushCnt = '0;
          for (int l = 0; l < PUSH_W; l++) begin
            wrEn[l] = 1'b0;
          end
        end
        headNext  = head + IDX_W'(popCnt);
        tailNext  = tail + IDX_W'(pushCnt);
        countNext = CNT_W'(CW'(count) - popCnt + pushCnt);
      end

      default: stateNext = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      initCnt     <= '0;
      errOverflow <= 1'b0;
    end else begin
      state       <= stateNext;
      head        <= headNext;
      tail        <= tailNext;
      count       <= countNext;
      initCnt     <= initCntNext;
      errOverflow <= errOverflow | ovfSet;
    end
  end

  // Storage contents are don't-care until written, so no reset here.
  always_ff @(posedge clk) begin
    for (int j = 0; j < PUSH_W; j++) begin
      if (wrEn[j]) begin
        mem[wrAddr[j]] <= wrData[j];
      end
    end
  end

endmodule

// File: tb/tb_iq_index_free_list.sv
// -----------------------------------------------------------------------------
// tb_iq_index_free_list
//   Reference model: a queue of free indices plus a per-index "allocated" flag.
//   The driver computes each cycle's expected allocations from the model and
//   pushes them into exp_q; a negedge monitor pops exp_q whenever the DUT
//   performs an allocation and compares allocPtr.
// -----------------------------------------------------------------------------
module tb_iq_index_free_list;

  localparam int N  = 16;
  localparam int IW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   allocReq = '0;
  logic [7:0]   allocPtr;
  logic         canAlloc;
  logic [3:0]   releaseValid = '0;
  logic [15:0]  releasePtr = '0;
  logic [1:0]   returnValid = '0;
  logic [7:0]   returnPtr = '0;
  logic [4:0]   freeCount;
  logic         initDone;
  logic         errOverflow;
  logic         dbgState;

  iq_index_free_list dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .allocReq     (allocReq),
    .allocPtr     (allocPtr),
    .canAlloc     (canAlloc),
    .releaseValid (releaseValid),
    .releasePtr   (releasePtr),
    .returnValid  (returnValid),
    .returnPtr    (returnPtr),
    .freeCount    (freeCount),
    .initDone     (initDone),
    .errOverflow  (errOverflow),
    .dbgState     (dbgState)
  );

  // clock
  always #5 clk = ~clk;

  int passCnt  = 0;
  int totalCnt = 0;

  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] freeQ[$];
  bit            outst[N];
  bit            mReady;
  bit            mOvf;
  int            mFillNext;

  task automatic check(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (allocReq[i] && canAlloc) begin
          if (exp_q.size() == 0) begin
            check("alloc_unexpected", int'(allocPtr[i*IW +: IW]), -1);
          end else begin
            check("alloc_ptr", int'(allocPtr[i*IW +: IW]), int'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic checkOutputs();
    check("free_count", int'(freeCount), freeQ.size());
    check("can_alloc", int'(canAlloc), int'(mReady && freeQ.size() >= 2));
    check("init_done", int'(initDone), int'(mReady));
    check("dbg_state", int'(dbgState), int'(mReady));
    check("err_overflow", int'(errOverflow), int'(mOvf));
  endtask

  // One clock cycle of stimulus; model advanced after the edge.
  task automatic drive(input logic [1:0] aReq, input logic [3:0] rV, input logic [15:0] rP,
                       input logic [1:0] tV, input logic [7:0] tP);
    int pops;
    logic [IW-1:0] pushList[$];
    allocReq     = aReq;
    releaseValid = rV;
    releasePtr   = rP;
    returnValid  = tV;
    returnPtr    = tP;
    pops = 0;
    if (mReady && freeQ.size() >= 2) pops = int'(aReq[0]) + int'(aReq[1]);
    for (int i = 0; i < pops; i++) exp_q.push_back(freeQ[i]);
    @(posedge clk);
    #1;
    if (!mReady) begin
      for (int k = 0; k < 6 && mFillNext < N; k++) begin
        freeQ.push_back(IW'(mFillNext));
        mFillNext++;
      end
      if (mFillNext == N) mReady = 1'b1;
    end else begin
      for (int l = 0; l < 4; l++) if (rV[l]) pushList.push_back(rP[l*IW +: IW]);
      for (int l = 0; l < 2; l++) if (tV[l]) pushList.push_back(tP[l*IW +: IW]);
      if (freeQ.size() - pops + pushList.size() > N) begin
        mOvf = 1'b1;
        pushList.delete();
      end
      for (int i = 0; i < pops; i++) outst[freeQ.pop_front()] = 1'b1;
      foreach (pushList[k]) begin
        freeQ.push_back(pushList[k]);
        outst[pushList[k]] = 1'b0;
      end
    end
    checkOutputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 4'b0, 16'h0, 2'b0, 8'h0);
  endtask

  // Asserts reset between edges, checks outputs clear at once, releases later.
  task automatic resetDut();
    allocReq = '0; releaseValid = '0; returnValid = '0;
    rst_n = 1'b0;
    #1;
    check("rst_free_count", int'(freeCount), 0);
    check("rst_can_alloc", int'(canAlloc), 0);
    check("rst_init_done", int'(initDone), 0);
    check("rst_err_overflow", int'(errOverflow), 0);
    exp_q.delete();
    freeQ.delete();
    foreach (outst[i]) outst[i] = 1'b0;
    mReady = 1'b0; mOvf = 1'b0; mFillNext = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Randomly choose allocated indices to hand back on release/return lanes.
  task automatic pickRet(input int pct, output logic [3:0] rV, output logic [15:0] rP,
                         output logic [1:0] tV, output logic [7:0] tP);
    logic [IW-1:0] avail[$];
    int j;
    logic [IW-1:0] v;
    rV = '0; rP = '0; tV = '0; tP = '0;
    for (int i = 0; i < N; i++) if (outst[i]) avail.push_back(IW'(i));
    for (int l = 0; l < 6; l++) begin
      if (avail.size() > 0 && $urandom_range(99) < pct) begin
        j = $urandom_range(avail.size() - 1);
        v = avail[j];
        avail.delete(j);
        if (l < 4) begin
          rV[l] = 1'b1; rP[l*IW +: IW] = v;
        end else begin
          tV[l-4] = 1'b1; tP[(l-4)*IW +: IW] = v;
        end
      end
    end
  endtask

  function automatic int outstCount();
    int n = 0;
    foreach (outst[i]) n += int'(outst[i]);
    return n;
  endfunction

  initial begin
    logic [3:0]  rV;
    logic [15:0] rP;
    logic [1:0]  tV;
    logic [7:0]  tP;
    logic [1:0]  aReq;

    // reset and init fill
    #2;
    resetDut();
    idle(3);
    check("init_alloc_ptr", int'(allocPtr), 'h10);

    // drain all 16 indices, then a dropped 9th request
    for (int i = 0; i < 8; i++) drive(2'b11, 4'b0, 16'h0, 2'b0, 8'h0);
    drive(2'b11, 4'b0, 16'h0, 2'b0, 8'h0);

    // combined release + return from empty
    drive(2'b00, 4'b1111, {4'd1, 4'd9, 4'd7, 4'd3}, 2'b11, {4'd5, 4'd2});
    for (int i = 0; i < 3; i++) drive(2'b11, 4'b0, 16'h0, 2'b0, 8'h0);

    // pop and push in the same cycle
    drive(2'b00, 4'b1111, {4'd8, 4'd6, 4'd4, 4'd0}, 2'b0, 8'h0);
    drive(2'b11, 4'b0001, 16'h000c, 2'b0, 8'h0);

    // fill to 16, then overflow
    while (outstCount() > 0) begin
      pickRet(100, rV, rP, tV, tP);
      drive(2'b00, rV, rP, tV, tP);
    end
    drive(2'b00, 4'b0001, 16'h0004, 2'b0, 8'h0);
    idle(3);

    // reset mid-init, then full in-order drain after re-init
    #1;
    resetDut();
    idle(1);
    #1;
    resetDut();
    idle(3);
    for (int i = 0; i < 8; i++) drive(2'b11, 4'b0, 16'h0, 2'b0, 8'h0);

    // randomized traffic with a reset during flush return
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        pickRet(100, rV, rP, tV, tP);
        drive(2'b00, 4'b0, 16'h0, tV, tP);
        #1;
        resetDut();
      end
      case ($urandom_range(2))
        0: aReq = 2'b00;
        1: aReq = 2'b01;
        default: aReq = 2'b11;
      endcase
      pickRet(30, rV, rP, tV, tP);
      drive(aReq, rV, rP, tV, tP);
    end

    idle(2);
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/iq_index_free_list.md
Name: iq_index_free_list

Overview:
- Free list of issue-queue entry indices, sitting between dispatch and the issue queue.
- Dispatch pops free indices to allocate entries.
- Indices come back on two paths:
  - issue/select releases entries, up to RELEASE_WIDTH per cycle;
  - the selective-flush return port delivers RETURN_WIDTH indices per cycle over multiple cycles.
- After reset, an init FSM fills the list with every index, RELEASE_WIDTH+RETURN_WIDTH indices per cycle.

Parameters:
- ENTRY_NUM, 16, number of issue-queue entries; must be a power of two.
- DISPATCH_WIDTH, 2, maximum pops per cycle.
- RELEASE_WIDTH, 4, maximum issue-release pushes per cycle.
- RETURN_WIDTH, 2, maximum flush-return pushes per cycle.
- IDX_W, $clog2(ENTRY_NUM), index width; count width is IDX_W+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- allocReq  in  DISPATCH_WIDTH  per-lane pop request; requesting lanes form a prefix (lane i set implies lanes below i set).
- allocPtr  out  DISPATCH_WIDTH*IDX_W  lane i = storage[head+i]; combinational, valid in the same cycle.
- canAlloc  out  1  READY && freeCount >= DISPATCH_WIDTH.
- releaseValid  in  RELEASE_WIDTH  issue-release lane valid.
- releasePtr  in  RELEASE_WIDTH*IDX_W  released indices.
- returnValid  in  RETURN_WIDTH  flush-return lane valid.
- returnPtr  in  RETURN_WIDTH*IDX_W  returned indices.
- freeCount  out  IDX_W+1  registered count of free indices.
- initDone  out  1  high in READY.
- errOverflow  out  1  sticky overflow error flag.

Behaviour:
- Storage is a circular buffer of ENTRY_NUM indices with head, tail (IDX_W bits, wrap by natural overflow) and count.
- Async reset (any time, including mid-init or mid-flush-return):
  - state=INIT, head=tail=0, count=0, initCnt=0;
  - errOverflow=0, canAlloc=0, initDone=0, freeCount=0.
  - Storage contents need no reset.
- INIT state:
  - Each cycle writes min(RELEASE_WIDTH+RETURN_WIDTH, ENTRY_NUM-initCnt) consecutive values starting at initCnt into slots tail, tail+1, and so on.
  - tail, count and initCnt advance by that amount.
  - When initCnt reaches ENTRY_NUM, the next state is READY. With defaults, the fill takes 3 cycles (6, 6, 4 indices).
  - allocReq, releaseValid and returnValid are ignored in INIT.
- READY pop:
  - pops = popcount(allocReq) if canAlloc, else 0. A request while !canAlloc is dropped; head is unchanged.
  - head += pops.
- READY push:
  - Valid lanes are compacted in the order release lanes 0..RELEASE_WIDTH-1, then return lanes 0..RETURN_WIDTH-1.
  - They are written to tail, tail+1, and so on; tail += pushes.
- Count update: count_next = count - pops + pushes.
  - Pops read storage at the current head.
  - An index pushed this cycle is not poppable until the next cycle; there is no bypass.
  - canAlloc uses the registered count.
- Overflow: if count - pops + pushes > ENTRY_NUM, that cycle's pushes are all dropped (tail unchanged) and errOverflow is set. errOverflow clears only on reset.
- Wrap-around: pointers wrap modulo ENTRY_NUM. When count=ENTRY_NUM, head==tail is full; when count=0, head==tail is empty.
- Release and flush return may be valid in the same cycle as each other and as pops; all three take effect together.
- No duplicate detection; the producer guarantees uniqueness.

Test Plan:
- Reset, then release rst_n -> initDone rises after 3 cycles; freeCount=16; canAlloc=1; allocPtr={1,0}.
- 8 consecutive cycles with allocReq=2'b11 -> indices 0..15 are allocated in order; freeCount reaches 0; canAlloc=0 on the cycle after the 8th pop; a 9th request leaves head unchanged.
- From empty, one cycle with releaseValid=4'b1111 (3,7,9,1) and returnValid=2'b11 (2,5) -> freeCount=6; the next three allocs give {3,7}, {9,1}, {2,5}.
- Same cycle: allocReq=11 with freeCount=4, plus releaseValid=4'b0001 (ptr 12) -> freeCount=3; the popped indices are the old head pair; 12 is appended at the tail.
- At freeCount=16, releaseValid=1 (ptr 4) -> push dropped; freeCount stays 16; errOverflow=1 until the next reset.
- Assert rst_n low mid-flush-return and mid-init -> outputs go to 0 immediately; re-init yields indices 0..15 again.
